// File: rtl/aes128_key_expand_stream.sv
// Iterative AES-128 key schedule: one expansion step per accepted beat, streaming
// round keys 0..NR on a valid/ready interface toward the round datapath.
module aes128_key_expand_stream #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         idle,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         done
);

    generate
        if (NR != 10) begin : gNrCheck
            $error("aes128_key_expand_stream supports only NR = 10 (AES-128)");
        end
    endgenerate

    localparam logic [3:0] lastIndex = 4'(NR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } state_t;

    state_t       state, nextState;
    logic [127:0] rkOutNext;
    logic [3:0]   rkIndexNext;
    logic         rkValidNext, doneNext, idleNext;

    function automatic logic [7:0] subByte(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] rconByte(input logic [3:0] round);
        logic [7:0] rc;
        rc = 8'h00;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One FIPS-197 expansion step: four new words from the previous round key.
    function automatic logic [127:0] expandKey(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] p3, rot, t, n0, n1, n2, n3;
        p3  = prev[31:0];
        rot = {p3[23:0], p3[31:24]};
        t   = {subByte(rot[31:24]), subByte(rot[23:16]), subByte(rot[15:8]), subByte(rot[7:0])}
              ^ {rc, 24'h000000};
        n0  = prev[127:96] ^ t;
        n1  = prev[95:64] ^ n0;
        n2  = prev[63:32] ^ n1;
        n3  = p3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        nextState   = state;
        rkOutNext   = rk_out;
        rkIndexNext = rk_index;
        rkValidNext = rk_valid;
        doneNext    = 1'b0;
        idleNext    = idle;
        case (state)
            IDLE: begin
                idleNext = 1'b1;
                if (start) begin
                    rkOutNext   = key_in;
                    rkIndexNext = 4'd0;
                    rkValidNext = 1'b1;
                    idleNext    = 1'b0;
                    nextState   = STREAM;
                end
            end
            STREAM: begin
                if (rk_valid && rk_ready) begin
                    if (rk_index == lastIndex) begin
                        rkValidNext = 1'b0;
                        doneNext    = 1'b1;
                        nextState   = FIN;
                    end else begin
                        rkOutNext   = expandKey(rk_out, rconByte(rk_index + 4'd1));
                        rkIndexNext = rk_index + 4'd1;
                    end
                end
            end
            FIN: begin
                idleNext  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (!rst_n) begin
            state    <= IDLE;
            idle     <= 1'b1;
            rk_valid <= 1'b0;
            rk_out   <= '0;
            rk_index <= 4'd0;
            done     <= 1'b0;
        end else begin
            state    <= nextState;
            idle     <= idleNext;
            rk_valid <= rkValidNext;
            rk_out   <= rkOutNext;
            rk_index <= rkIndexNext;
            done     <= doneNext;
        end
    end

endmodule

// File: tb/tb_aes128_key_expand_stream.sv
// Scoreboard bench for aes128_key_expand_stream: a FIPS-197 word-array key schedule
// (S-box derived from GF(2^8) inverse + affine map) predicts every accepted beat.
module tb_aes128_key_expand_stream;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } beat_t;

    localparam logic [127:0] fipsKey   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] fipsR1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] fipsR10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] zeroR1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] zeroR10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         idle;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         done;

    aes128_key_expand_stream #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .idle     (idle),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_index (rk_index),
        .done     (done)
    );

    int           vectors = 0;
    int           miscompares = 0;
    beat_t        expQ[$];
    logic [7:0]   sboxModel[256];
    logic [127:0] captured[11];
    int           doneCount = 0;
    int           readyMode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sboxModel[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 KeyExpansion over the 44-word array; one beat per group of 4 words.
    task automatic pushStream(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        beat_t       b;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxModel[t[31:24]], sboxModel[t[23:16]], sboxModel[t[15:8]], sboxModel[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            b.idx = 4'(r);
            b.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            expQ.push_back(b);
        end
    endtask

    // rk_ready driver: mode 0 holds ready high, mode 1 toggles it with occasional 5-cycle stalls.
    initial begin
        int stallLeft;
        int r;
        stallLeft = 0;
        rk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 0) begin
                rk_ready = 1'b1;
            end else if (stallLeft > 0) begin
                rk_ready = 1'b0;
                stallLeft--;
            end else begin
                r = $urandom_range(0, 7);
                if (r == 0) begin
                    stallLeft = 4;
                    rk_ready = 1'b0;
                end else begin
                    rk_ready = (r > 2);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing.
    initial begin
        logic         prevStall;
        logic         pendDone;
        logic [3:0]   prevIdx;
        logic [127:0] prevKey;
        beat_t        e;
        prevStall = 1'b0;
        pendDone  = 1'b0;
        prevIdx   = 4'd0;
        prevKey   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
                pendDone  = 1'b0;
            end else begin
                if (done || pendDone) check("done_pulse", 128'(done), 128'(pendDone));
                if (done) doneCount++;
                pendDone = 1'b0;
                if (prevStall) begin
                    check("stall_valid", 128'(rk_valid), 128'(1'b1));
                    check("stall_index", 128'(rk_index), 128'(prevIdx));
                    check("stall_key", rk_out, prevKey);
                end
                if (rk_valid && rk_ready) begin
                    check("beat_queued", 128'(expQ.size() > 0), 128'(1'b1));
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        check("beat_index", 128'(rk_index), 128'(e.idx));
                        check("beat_key", rk_out, e.key);
                    end
                    if (rk_index <= 4'd10) captured[rk_index] = rk_out;
                    if (rk_index == 4'd10) pendDone = 1'b1;
                end
                prevStall = rk_valid && !rk_ready;
                prevIdx   = rk_index;
                prevKey   = rk_out;
            end
        end
    end

    task automatic startBeat(input logic [127:0] key);
        int n;
        n = 0;
        while (!idle && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_before_start", 128'(idle), 128'(1'b1));
        start  = 1'b1;
        key_in = key;
        pushStream(key);
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finishStream(input int c0);
        int n;
        n = 0;
        while (doneCount == c0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen_once", 128'(doneCount), 128'(c0 + 1));
        check("queue_drained", 128'(expQ.size()), 128'(0));
    endtask

    task automatic runStream(input logic [127:0] key);
        int c0;
        c0 = doneCount;
        startBeat(key);
        finishStream(c0);
    endtask

    initial begin
        int n;
        int c0;
        logic [127:0] kA;
        logic [127:0] kB;
        rst_n  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        buildSbox();

        // Reset values without any clock edge dependence.
        #1 rst_n = 1'b0;
        #2;
        check("rst_idle", 128'(idle), 128'(1'b1));
        check("rst_valid", 128'(rk_valid), 128'(1'b0));
        check("rst_out", rk_out, 128'h0);
        check("rst_index", 128'(rk_index), 128'(0));
        check("rst_done", 128'(done), 128'(1'b0));
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS key, ready held high: latency and known round keys.
        readyMode = 0;
        c0 = doneCount;
        startBeat(fipsKey);
        check("s1_valid", 128'(rk_valid), 128'(1'b1));
        check("s1_index0", 128'(rk_index), 128'(0));
        check("s1_key0", rk_out, fipsKey);
        check("s1_idle_low", 128'(idle), 128'(1'b0));
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s1_done_latency", 128'(n), 128'(11));
        check("s1_fin_idle", 128'(idle), 128'(1'b0));
        check("s1_fin_index", 128'(rk_index), 128'(10));
        check("s1_fin_key", rk_out, fipsR10);
        @(posedge clk);
        #1;
        check("s1_done_drop", 128'(done), 128'(1'b0));
        check("s1_idle_back", 128'(idle), 128'(1'b1));
        finishStream(c0);
        check("s1_round1", captured[1], fipsR1);
        check("s1_round10", captured[10], fipsR10);

        // All-zero key.
        runStream(128'h0);
        check("s2_round1", captured[1], zeroR1);
        check("s2_round10", captured[10], zeroR10);

        // FIPS key under random backpressure.
        readyMode = 1;
        runStream(fipsKey);
        check("s3_round1", captured[1], fipsR1);
        check("s3_round10", captured[10], fipsR10);

        // start with a new key mid-stream must be ignored.
        readyMode = 0;
        c0 = doneCount;
        startBeat(fipsKey);
        n = 0;
        while (rk_index != 4'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s4_reach_idx4", 128'(rk_index), 128'(4));
        start  = 1'b1;
        key_in = 128'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        finishStream(c0);
        check("s4_round10", captured[10], fipsR10);

        // Asynchronous reset mid-stream, then a fresh start.
        startBeat(fipsKey);
        n = 0;
        while (rk_index != 4'd6 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s5_reach_idx6", 128'(rk_index), 128'(6));
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", 128'(rk_valid), 128'(1'b0));
        check("s5_rst_idle", 128'(idle), 128'(1'b1));
        check("s5_rst_out", rk_out, 128'h0);
        check("s5_rst_done", 128'(done), 128'(1'b0));
        expQ.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        runStream(128'h0);
        check("s5_round1", captured[1], zeroR1);

        // start held through FIN and the following cycle: only the second is taken.
        kA = {$urandom, $urandom, $urandom, $urandom};
        kB = {$urandom, $urandom, $urandom, $urandom};
        c0 = doneCount;
        startBeat(kA);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s6_in_fin", 128'(done), 128'(1'b1));
        start  = 1'b1;
        key_in = ~kB;
        @(posedge clk);
        #1;
        check("s6_idle_after_fin", 128'(idle), 128'(1'b1));
        check("s6_fin_start_ignored", 128'(rk_valid), 128'(1'b0));
        finishStream(c0);
        c0 = doneCount;
        key_in = kB;
        pushStream(kB);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("s6_valid", 128'(rk_valid), 128'(1'b1));
        check("s6_index0", 128'(rk_index), 128'(0));
        check("s6_key0", rk_out, kB);
        finishStream(c0);

        // Random keys under random backpressure.
        readyMode = 1;
        for (int k = 0; k < 6; k++)
            runStream({$urandom, $urandom, $urandom, $urandom});

        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 128'(idle), 128'(1'b1));
        check("final_queue", 128'(expQ.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes128_key_expand_stream.md
Name: aes128_key_expand_stream

Overview:
- Iterative AES-128 key schedule sitting directly upstream of encrypt_round.
- Takes a 128-bit cipher key on a start pulse and produces round keys 0..NR, one per beat, on a valid/ready stream.
- The round controller consumes this stream and feeds it to the key input of encrypt_round.
- Each beat computes one expansion step of 4 words, so no 176-byte key store is needed.

Parameters:
- NR, 10, number of rounds. Only 10 is legal (AES-128). The Rcon table covers rounds 1..10. Any other value is a synthesis error via elaboration-time check.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to expand key_in; sampled only when idle=1
- key_in  input  128  cipher key. [127:96]=w0, [31:0]=w3; byte [127:120] is the first key byte (FIPS-197 order)
- idle  output  1  high when able to accept start
- rk_valid  output  1  rk_out/rk_index hold a valid round key
- rk_ready  input  1  consumer accepts the current beat when rk_valid&rk_ready
- rk_out  output  128  round key, same word/byte ordering as key_in
- rk_index  output  4  round number of rk_out, 0..NR
- done  output  1  one-cycle pulse after round key NR is accepted

Behaviour:
- Reset (async assert, sync release is the integrator's job):
  - State=IDLE, idle=1, rk_valid=0, rk_out=0, rk_index=0, done=0.
- States:
  - IDLE, STREAM, FIN.
- IDLE:
  - idle=1.
  - start=1 at edge t: rk_out<=key_in, rk_index<=0, rk_valid<=1, state<=STREAM.
  - idle=0 from t+1.
  - start=0: remain in IDLE.
- STREAM:
  - rk_out and rk_index are stable while rk_valid=1 and rk_ready=0; no change under backpressure.
  - Handshake with rk_index<NR: rk_out<=expand(rk_out, Rcon[rk_index+1]); rk_index<=rk_index+1; rk_valid stays 1.
  - Result: with rk_ready held high, indices 0..10 appear on 11 consecutive cycles.
  - Handshake with rk_index==NR: rk_valid<=0, done<=1, state<=FIN.
- FIN:
  - Lasts exactly one cycle; done=1, idle=0.
  - Next cycle: done<=0, idle<=1, state<=IDLE.
  - rk_out retains the last key; rk_index retains NR.
- expand(prev, rc), with prev words p0..p3 (p0 = bits [127:96]):
  - t = SubWord(RotWord(p3)) xor {rc,24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - n0=p0^t, n1=p1^n0, n2=p2^n1, n3=p3^n2.
  - All of this is combinational within one cycle.
- SubWord:
  - Four byte-wide FIPS-197 S-box lookups, implemented in this block as constant case tables.
  - Values are bit-identical to the Sub_bytes S-box.
- Rcon[1..10]:
  - 01,02,04,08,10,20,40,80,1B,36.
- Boundaries:
  - start while not idle: ignored, no effect on the current stream.
  - start in the same cycle FIN returns to IDLE: ignored; idle is registered and still 0 in that cycle.
  - rk_ready may be high while rk_valid=0: no effect.
  - rk_ready low indefinitely: the block holds the beat forever; no timeout.
  - key_in is sampled only at the accepted start edge, so later changes are irrelevant.
  - rst_n low at any point, including mid-stream or during FIN: immediate return to reset values. No partial done pulse.
  - rk_valid, once asserted, never drops without a handshake (except on reset).

Test Plan:
- Reset then start, key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> cycle t+1 rk_index=0, rk_out=key_in; t+2 rk_out=a0fafe1788542cb123a339392a6c7605; t+11 rk_index=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6; done=1 at t+12 only; idle=1 at t+13.
- key_in=0, rk_ready=1 -> round1 = 62636363626363636263636362636363; round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- FIPS key with rk_ready toggled pseudo-randomly, including 5-cycle stalls -> rk_out/rk_index are constant during every stall; the sequence of accepted keys is identical to scenario 1; done fires exactly once.
- start pulsed at rk_index=4, with key_in changed to 0 -> stream continues the FIPS key; round10 = d014f9a8...; no restart.
- rst_n pulled low while rk_index=6 with rk_valid=1 -> rk_valid=0, idle=1, rk_out=0 immediately without a clock edge. A fresh start with key 0 then yields round1 = 626363...63.
- start asserted in the FIN cycle and the following cycle -> the first is ignored; the second is accepted, with rk_index=0 and rk_valid one cycle later.
